// File: rtl/queue_scheduler.sv
// Queue scheduler: arbitrates between a deserializer writing into a shared
// queue and two consumers (A/B) reading from it. One operation at a time,
// always returning through IDLE so len_in settles before re-evaluation.
module queue_scheduler #(
  parameter int DEPTH       = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clock1M,
  input  logic       reset,
  input  logic       data_ready,
  input  logic [7:0] len_in,
  input  logic       deq_req_a,
  input  logic       deq_req_b,
  output logic       enqueue_out,
  output logic       ack_out,
  output logic       dequeue_out,
  output logic       grant_a,
  output logic       grant_b,
  output logic       full_out,
  output logic       empty_out,
  output logic [7:0] stall_cnt,
  output logic       err_timeout
);

  typedef enum logic [1:0] {IDLE, ENQ, ACK, DEQ} state_t;

  localparam logic [7:0] LP_DEPTH    = 8'(DEPTH);
  localparam logic [4:0] LP_ACK_LAST = 5'(ACK_TIMEOUT - 1);

  state_t     r_state, w_state_nxt;
  logic       r_last_was_enq, w_lwe_nxt;
  logic       r_rr, w_rr_nxt;
  logic [4:0] r_ack_cnt, w_cnt_nxt;
  logic       w_enq_nxt, w_ack_nxt, w_deq_nxt, w_ga_nxt, w_gb_nxt, w_err_nxt;
  logic [7:0] w_stall_nxt;
  logic       w_enq_cand, w_deq_cand, w_pick_b;

  assign full_out   = (len_in >= LP_DEPTH);
  assign empty_out  = (len_in == 8'd0);
  assign w_enq_cand = data_ready && !full_out;
  assign w_deq_cand = (deq_req_a || deq_req_b) && !empty_out;
  // B wins when it is the only requester, or both request and rr favours B.
  assign w_pick_b   = deq_req_b && (!deq_req_a || r_rr);

  // Next-state and next-output decode; outputs are registered from these so
  // each strobe is aligned with the state that owns it.
  always_comb begin
    w_state_nxt = r_state;
    w_lwe_nxt   = r_last_was_enq;
    w_rr_nxt    = r_rr;
    w_cnt_nxt   = r_ack_cnt;
    w_enq_nxt   = 1'b0;
    w_ack_nxt   = 1'b0;
    w_deq_nxt   = 1'b0;
    w_ga_nxt    = 1'b0;
    w_gb_nxt    = 1'b0;
    w_err_nxt   = err_timeout;
    w_stall_nxt = stall_cnt;
    case (r_state)
      IDLE: begin
        if (data_ready && full_out && stall_cnt != 8'hFF)
          w_stall_nxt = stall_cnt + 8'd1;
        if (w_enq_cand && (!w_deq_cand || !r_last_was_enq)) begin
          w_state_nxt = ENQ;
          w_enq_nxt   = 1'b1;
        end else if (w_deq_cand) begin
          w_state_nxt = DEQ;
          w_deq_nxt   = 1'b1;
          w_ga_nxt    = !w_pick_b;
          w_gb_nxt    = w_pick_b;
          w_rr_nxt    = !w_pick_b;  // point at the consumer not granted
        end
      end
      ENQ: begin
        w_lwe_nxt   = 1'b1;
        w_state_nxt = ACK;
        w_ack_nxt   = 1'b1;
        w_cnt_nxt   = 5'd0;
      end
      ACK: begin
        if (!data_ready) begin
          w_state_nxt = IDLE;
        end else if (r_ack_cnt == LP_ACK_LAST) begin
          w_state_nxt = IDLE;
          w_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt   = r_ack_cnt + 5'd1;
          w_ack_nxt   = 1'b1;
        end
      end
      DEQ: begin
        w_lwe_nxt   = 1'b0;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clock1M or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_last_was_enq <= 1'b0;
      r_rr           <= 1'b0;
      r_ack_cnt      <= 5'd0;
      enqueue_out    <= 1'b0;
      ack_out        <= 1'b0;
      dequeue_out    <= 1'b0;
      grant_a        <= 1'b0;
      grant_b        <= 1'b0;
      stall_cnt      <= 8'd0;
      err_timeout    <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_last_was_enq <= w_lwe_nxt;
      r_rr           <= w_rr_nxt;
      r_ack_cnt      <= w_cnt_nxt;
      enqueue_out    <= w_enq_nxt;
      ack_out        <= w_ack_nxt;
      dequeue_out    <= w_deq_nxt;
      grant_a        <= w_ga_nxt;
      grant_b        <= w_gb_nxt;
      stall_cnt      <= w_stall_nxt;
      err_timeout    <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_queue_scheduler.sv
// Directed bench for queue_scheduler: linear stimulus with hand-computed
// expectations, checked by immediate assertions.
module tb_queue_scheduler;

  logic       clock1M = 1'b0;
  logic       reset;
  logic       data_ready;
  logic [7:0] len_in;
  logic       deq_req_a, deq_req_b;
  logic       enqueue_out, ack_out, dequeue_out, grant_a, grant_b;
  logic       full_out, empty_out, err_timeout;
  logic [7:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  queue_scheduler #(.DEPTH(8), .ACK_TIMEOUT(16)) dut (
    .clock1M(clock1M), .reset(reset), .data_ready(data_ready), .len_in(len_in),
    .deq_req_a(deq_req_a), .deq_req_b(deq_req_b), .enqueue_out(enqueue_out),
    .ack_out(ack_out), .dequeue_out(dequeue_out), .grant_a(grant_a),
    .grant_b(grant_b), .full_out(full_out), .empty_out(empty_out),
    .stall_cnt(stall_cnt), .err_timeout(err_timeout)
  );

  always #5 clock1M = ~clock1M;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clock1M);
    #1;
  endtask

  task automatic rst_pulse();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; data_ready = 1'b0; len_in = 8'd0;
    deq_req_a = 1'b0; deq_req_b = 1'b0;
    #2;
    // Reset state
    chk("rst_enq", enqueue_out, 0); chk("rst_ack", ack_out, 0);
    chk("rst_deq", dequeue_out, 0); chk("rst_ga", grant_a, 0);
    chk("rst_gb", grant_b, 0); chk("rst_stall", stall_cnt, 0);
    chk("rst_err", err_timeout, 0); chk("rst_empty", empty_out, 1);
    chk("rst_full", full_out, 0);
    step(); step();
    reset = 1'b1;

    // Single write, data_ready dropped 2 cycles after ack rises
    data_ready = 1'b1;
    step(); chk("sw_enq", enqueue_out, 1); chk("sw_ack0", ack_out, 0);
    step(); chk("sw_enq_once", enqueue_out, 0); chk("sw_ack_c1", ack_out, 1);
    step(); chk("sw_ack_c2", ack_out, 1);
    step(); chk("sw_ack_c3", ack_out, 1);
    data_ready = 1'b0;
    step(); chk("sw_ack_drop", ack_out, 0);
    step(); chk("sw_idle_enq", enqueue_out, 0); chk("sw_idle_ack", ack_out, 0);

    // Full stall: 10 cycles of data_ready while full
    len_in = 8'd8; data_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(); chk("fs_no_enq", enqueue_out, 0);
    end
    chk("fs_full", full_out, 1); chk("fs_empty", empty_out, 0);
    data_ready = 1'b0;
    chk("fs_stall10", stall_cnt, 10);
    step(); chk("fs_stall_hold", stall_cnt, 10);

    // Contention: ENQ first (last_was_enq=0), then alternate with DEQ grant A
    len_in = 8'd3; data_ready = 1'b1; deq_req_a = 1'b1;
    rst_pulse();
    step(); chk("ct_enq1", enqueue_out, 1); chk("ct_deq1", dequeue_out, 0);
    step(); chk("ct_ack1", ack_out, 1);
    data_ready = 1'b0;
    step(); chk("ct_ack1_drop", ack_out, 0);
    data_ready = 1'b1;
    step(); chk("ct_deq2", dequeue_out, 1); chk("ct_ga2", grant_a, 1);
    chk("ct_gb2", grant_b, 0); chk("ct_enq2", enqueue_out, 0);
    step(); chk("ct_deq2_once", dequeue_out, 0); chk("ct_ga2_off", grant_a, 0);
    step(); chk("ct_enq3", enqueue_out, 1); chk("ct_deq3", dequeue_out, 0);
    step(); chk("ct_ack3", ack_out, 1);
    data_ready = 1'b0;
    step(); chk("ct_ack3_drop", ack_out, 0);
    data_ready = 1'b1;
    step(); chk("ct_deq4", dequeue_out, 1); chk("ct_ga4", grant_a, 1);
    data_ready = 1'b0; deq_req_a = 1'b0;
    step(); chk("ct_end", dequeue_out, 0);

    // Round-robin A,B,A,B with both consumers requesting
    len_in = 8'd5; deq_req_a = 1'b1; deq_req_b = 1'b1;
    rst_pulse();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_deq", dequeue_out, 1);
      chk("rr_ga", grant_a, (i % 2 == 0) ? 8'd1 : 8'd0);
      chk("rr_gb", grant_b, (i % 2 == 1) ? 8'd1 : 8'd0);
      step();
      chk("rr_gap", dequeue_out, 0);
    end
    // rr now favours A, but only B requests: B must win
    deq_req_a = 1'b0;
    step(); chk("rr_only_b_deq", dequeue_out, 1); chk("rr_only_b_gb", grant_b, 1);
    chk("rr_only_b_ga", grant_a, 0);
    // Empty queue: requests ignored
    len_in = 8'd0; deq_req_a = 1'b1; deq_req_b = 1'b0;
    step(); chk("em_gap", dequeue_out, 0);
    step(); chk("em_no_deq", dequeue_out, 0); chk("em_empty", empty_out, 1);
    step(); chk("em_no_deq2", dequeue_out, 0);
    deq_req_a = 1'b0;

    // Ack timeout: data_ready stuck high
    data_ready = 1'b1;
    step(); chk("to_enq", enqueue_out, 1);
    for (int i = 0; i < 16; i++) begin
      step(); chk("to_ack_hi", ack_out, 1);
    end
    chk("to_err_pre", err_timeout, 0);
    step(); chk("to_ack_drop", ack_out, 0); chk("to_err", err_timeout, 1);
    data_ready = 1'b0;
    step(); step(); chk("to_err_sticky", err_timeout, 1);

    // Stall counter saturation
    len_in = 8'd8; data_ready = 1'b1;
    repeat (260) step();
    chk("sat_255", stall_cnt, 8'hFF);

    // Reset mid-ACK
    len_in = 8'd0;
    step(); chk("ra_enq", enqueue_out, 1);
    step(); chk("ra_ack", ack_out, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("ra_ack_async", ack_out, 0); chk("ra_stall", stall_cnt, 0);
    chk("ra_err", err_timeout, 0); chk("ra_enq_off", enqueue_out, 0);
    step(); chk("ra_hold_ack", ack_out, 0);
    data_ready = 1'b0;
    reset = 1'b1;
    step(); chk("ra_idle_enq", enqueue_out, 0); chk("ra_idle_ack", ack_out, 0);
    data_ready = 1'b1;
    step(); chk("ra_from_idle", enqueue_out, 1);
    data_ready = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/queue_scheduler.md
QUEUE_SCHEDULER -- requirements
Module: queue_scheduler

Interface
REQ-001 Parameter DEPTH, default 8: queue capacity in entries; the full threshold compared against len_in.
REQ-002 Parameter ACK_TIMEOUT, default 16: maximum cycles ack_out is held waiting for data_ready to fall.
REQ-003 Port clock1M  input  1: single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1: asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port data_ready  input  1: deserializer holds a complete byte.
REQ-006 Port len_in  input  8: current queue occupancy.
REQ-007 Port deq_req_a  input  1: consumer A requests one byte.
REQ-008 Port deq_req_b  input  1: consumer B requests one byte.
REQ-009 Port enqueue_out  output  1: one-cycle queue write strobe.
REQ-010 Port ack_out  output  1: acknowledge to deserializer.
REQ-011 Port dequeue_out  output  1: one-cycle queue read strobe.
REQ-012 Port grant_a  output  1: read strobe belongs to consumer A; asserted in the same cycle as dequeue_out.
REQ-013 Port grant_b  output  1: read strobe belongs to consumer B; asserted in the same cycle as dequeue_out.
REQ-014 Port full_out  output  1: combinational flag, len_in >= DEPTH.
REQ-015 Port empty_out  output  1: combinational flag, len_in == 0.
REQ-016 Port stall_cnt  output  8: count of cycles in IDLE with data_ready=1 while full; saturates at 255.
REQ-017 Port err_timeout  output  1: sticky flag, set when an acknowledge times out.

Function
REQ-018 FSM states SHALL be IDLE, ENQ, ACK, DEQ; all outputs except full_out and empty_out SHALL be registered.
REQ-019 IDLE arbitration:
- Enqueue candidate: data_ready=1 and len_in<DEPTH.
- Dequeue candidate: (deq_req_a or deq_req_b)=1 and len_in>0.
REQ-020 If only one candidate is valid in IDLE, the FSM SHALL move to ENQ or DEQ accordingly; if neither is valid, it SHALL stay in IDLE.
REQ-021 If both candidates are valid, bit last_was_enq SHALL pick the winner: 1 selects DEQ, 0 selects ENQ.
REQ-022 ENQ SHALL drive enqueue_out=1 for exactly one cycle, set last_was_enq=1, then go to ACK.
REQ-023 ACK:
- ack_out=1 from ACK entry; a 5-bit counter starts at 0 on entry.
- Return to IDLE, with ack_out dropping, in the cycle after data_ready is sampled 0.
REQ-024 ACK timeout: if the counter reaches ACK_TIMEOUT-1 with data_ready still 1, the FSM SHALL set err_timeout=1, drop ack_out and return to IDLE.
REQ-025 DEQ SHALL drive dequeue_out=1 for exactly one cycle together with exactly one grant, set last_was_enq=0, then return to IDLE.
REQ-026 Consumer round-robin:
- rr=0 favours A, rr=1 favours B.
- If only one consumer requests, that consumer SHALL be granted regardless of rr.
- After each grant, rr SHALL point to the consumer not granted.
REQ-027 Every operation SHALL pass through IDLE before the next strobe, so strobes are never in consecutive cycles and len_in has settled one cycle before it is re-evaluated.
REQ-028 The FSM SHALL never assert enqueue_out when len_in>=DEPTH and never assert dequeue_out when len_in==0.
REQ-029 stall_cnt SHALL increment only in IDLE with data_ready=1 and len_in>=DEPTH, and SHALL hold at 255.
REQ-030 A request that drops before IDLE evaluates it SHALL be ignored; requests are level-sensitive and never latched.

Reset
REQ-031 With reset=0, the block SHALL asynchronously force:
- state=IDLE
- enqueue_out=0, ack_out=0, dequeue_out=0, grant_a=0, grant_b=0
- stall_cnt=0, err_timeout=0
- rr=0, last_was_enq=0, ACK counter=0
REQ-032 Reset asserted mid-ENQ, ACK or DEQ SHALL abort the operation immediately with no strobe completing afterwards.
REQ-033 After reset is released, the first state evaluation SHALL occur on the next clock1M rising edge.
REQ-034 err_timeout SHALL clear only on reset.

Verification
REQ-035 Single write: len_in=0, data_ready=1, data_ready dropped 2 cycles after ack_out rises -> enqueue_out pulses 1 cycle; ack_out high 3 cycles; FSM returns to IDLE.
REQ-036 Full stall: len_in=8, data_ready=1 for 10 cycles -> no enqueue_out; full_out=1; stall_cnt=10.
REQ-037 Contention: len_in=3, data_ready=1, deq_req_a=1 continuously, last_was_enq=0 -> ENQ first, then DEQ with grant_a; operations alternate thereafter.
REQ-038 Round-robin: len_in=5, both requests held with no enqueue -> grant sequence A,B,A,B; each grant paired with a dequeue_out pulse.
REQ-039 Timeout: data_ready stuck at 1 through ACK -> ack_out drops after 16 cycles; err_timeout=1 and stays 1.
REQ-040 Reset mid-ACK: reset=0 while ack_out=1 -> ack_out=0 asynchronously; stall_cnt=0; FSM in IDLE after release.
